dump_pos_collect: RTL and testbench

DUMP_POS_COLLECT -- requirements
Module: dump_pos_collect

---
 rtl/MD_pkg.sv | 20 ++
 rtl/dump_fifo.sv | 66 ++++++
 rtl/dump_pos_collect.sv | 132 +++++++++++++
 tb/tb_dump_pos_collect.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/MD_pkg.sv
// Shared widths, dump-path defaults and the dump entry record for the MD particle datapath.
package MD_pkg;

    localparam int NUM_INIT_STEPS         = 4;
    localparam int NUM_PARTICLES_PER_CELL = 8;
    localparam int PARTICLE_ID_WIDTH      = $clog2(NUM_PARTICLES_PER_CELL);
    localparam int INIT_STEP_WIDTH        = $clog2(NUM_INIT_STEPS);
    localparam int POS_WIDTH              = 16;

    localparam int DUMP_RD_LATENCY        = 2;
    localparam int DUMP_FIFO_DEPTH        = NUM_PARTICLES_PER_CELL;

    typedef struct packed {
        logic [INIT_STEP_WIDTH-1:0]   step;
        logic [PARTICLE_ID_WIDTH-1:0] id;
        logic [POS_WIDTH-1:0]         data;
        logic                         last;
    } dump_entry_t;

endpackage

// File: rtl/dump_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is taken only
// when a pop frees the slot in the same cycle, otherwise it is dropped and flagged.
module dump_fifo
    import MD_pkg::*;
#(
    parameter int  DEPTH   = DUMP_FIFO_DEPTH,
    parameter type entry_t = dump_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output logic   valid_o,
    output entry_t head_o,
    output logic   drop_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q < FULL_CNT) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign drop_o  = push_i && !do_push;

    assert property (@(posedge clk) disable iff (rst) count_q <= FULL_CNT);

endmodule

// File: rtl/dump_pos_collect.sv
// Collects per-step position reads issued by the dump address generator into a
// stream of {step, id, position, last} entries with valid/ready handshake.
module dump_pos_collect
    import MD_pkg::*;
#(
    parameter int NUM_STEPS  = NUM_INIT_STEPS,
    parameter int RD_LATENCY = DUMP_RD_LATENCY,
    parameter int FIFO_DEPTH = DUMP_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_STEPS-1:0]           dump_rd_en,
    input  logic [PARTICLE_ID_WIDTH-1:0]   dump_rd_addr,
    input  logic [NUM_STEPS*POS_WIDTH-1:0] step_rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [POS_WIDTH-1:0]           out_data,
    output logic [PARTICLE_ID_WIDTH-1:0]   out_id,
    output logic [INIT_STEP_WIDTH-1:0]     out_step,
    output logic                           out_last,
    output logic                           overflow,
    output logic                           proto_err,
    output logic                           busy
);

    localparam logic [PARTICLE_ID_WIDTH-1:0] LAST_ID = PARTICLE_ID_WIDTH'(NUM_PARTICLES_PER_CELL - 1);

    logic [NUM_STEPS-1:0]         en_q   [RD_LATENCY];
    logic [PARTICLE_ID_WIDTH-1:0] addr_q [RD_LATENCY];
    logic [NUM_STEPS-1:0]         en_dly;
    logic [PARTICLE_ID_WIDTH-1:0] addr_dly;
    logic                         inflight;

    logic [INIT_STEP_WIDTH-1:0]   step_idx;
    logic [POS_WIDTH-1:0]         pos_sel;
    logic                         multi_hot;
    dump_entry_t                  entry;
    dump_entry_t                  head;

    logic fifo_push, fifo_pop, fifo_valid, fifo_drop;
    logic overflow_q, overflow_d;
    logic proto_err_q, proto_err_d;

    // Enable and address travel together so each lands with the data it requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                en_q[i]   <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            en_q[0]   <= dump_rd_en;
            addr_q[0] <= dump_rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                en_q[i]   <= en_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign en_dly   = en_q[RD_LATENCY-1];
    assign addr_dly = addr_q[RD_LATENCY-1];

    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight | (en_q[i] != '0);
        end
    end

    // Descending scan so the lowest set bit is the one that sticks.
    always_comb begin
        step_idx = '0;
        pos_sel  = '0;
        for (int k = NUM_STEPS - 1; k >= 0; k--) begin
            if (en_dly[k]) begin
                step_idx = INIT_STEP_WIDTH'(k);
                pos_sel  = step_rd_data[k*POS_WIDTH +: POS_WIDTH];
            end
        end
    end

    assign multi_hot = ((en_dly & (en_dly - NUM_STEPS'(1))) != '0);

    always_comb begin
        entry      = '0;
        entry.step = step_idx;
        entry.id   = addr_dly;
        entry.data = pos_sel;
        entry.last = (addr_dly == LAST_ID);
    end

    assign fifo_push = (en_dly != '0);
    assign fifo_pop  = fifo_valid && out_ready;

    dump_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (dump_entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (entry),
        .pop_i       (fifo_pop),
        .valid_o     (fifo_valid),
        .head_o      (head),
        .drop_o      (fifo_drop)
    );

    assign overflow_d  = overflow_q | fifo_drop;
    assign proto_err_d = proto_err_q | multi_hot;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign out_valid = fifo_valid;
    assign out_data  = head.data;
    assign out_id    = head.id;
    assign out_step  = head.step;
    assign out_last  = head.last;
    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;
    assign busy      = inflight || fifo_valid;

endmodule

// File: tb/tb_dump_pos_collect.sv
// Randomised bench for dump_pos_collect: a queue-based reference model of the
// read-return pipe and dump FIFO scores every cycle; scenario tasks add targeted checks.
module tb_dump_pos_collect;
    import MD_pkg::*;

    localparam int NS    = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 8;
    localparam int IDW   = PARTICLE_ID_WIDTH;
    localparam int SW    = INIT_STEP_WIDTH;
    localparam int PW    = POS_WIDTH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NS-1:0]     dump_rd_en = '0;
    logic [IDW-1:0]    dump_rd_addr = '0;
    logic [NS*PW-1:0]  step_rd_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PW-1:0]     out_data;
    logic [IDW-1:0]    out_id;
    logic [SW-1:0]     out_step;
    logic              out_last;
    logic              overflow;
    logic              proto_err;
    logic              busy;

    dump_pos_collect #(
        .NUM_STEPS  (NS),
        .RD_LATENCY (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dump_rd_en   (dump_rd_en),
        .dump_rd_addr (dump_rd_addr),
        .step_rd_data (step_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_id       (out_id),
        .out_step     (out_step),
        .out_last     (out_last),
        .overflow     (overflow),
        .proto_err    (proto_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [NS-1:0] en; int addr; } req_t;
    typedef struct { int step; int id; int data; bit last; } exp_t;

    req_t pipe[$];
    exp_t q[$];
    bit   m_ovf, m_perr, m_busy;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   sb_on = 1'b0;
    int   first_valid_cyc = -1;
    int   got_ids[$];
    int   got_steps[$];
    int   got_last[$];

    bit            prev_stall = 1'b0;
    logic [PW-1:0] prev_data;
    logic [IDW-1:0] prev_id;
    logic [SW-1:0] prev_step;
    logic          prev_last;

    // Position memory content: slice k returns {k, addr}.
    function automatic int data_of(int k, int a);
        return (k << 8) | a;
    endfunction

    function automatic int inflight_cnt();
        int n = 0;
        foreach (pipe[i]) if (pipe[i].en != '0) n++;
        return n;
    endfunction

    task automatic tick(input logic [NS-1:0] en, input int addr, input bit rdy, input bit rs);
        req_t d;
        exp_t e;
        bit   pop, acc;
        int   k;
        @(negedge clk);
        if (sb_on) begin
            vectors++;
            if (out_valid !== (q.size() != 0)) begin
                miscompares++;
                $display("FAIL out_valid cyc %0d: got %b want %0d", cyc, out_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                vectors++;
                if (out_step !== SW'(q[0].step) || out_id !== IDW'(q[0].id) ||
                    out_data !== PW'(q[0].data) || out_last !== q[0].last) begin
                    miscompares++;
                    $display("FAIL head cyc %0d: got step %0d id %0d data %h last %b want step %0d id %0d data %h last %0d",
                             cyc, out_step, out_id, out_data, out_last, q[0].step, q[0].id, q[0].data, q[0].last);
                end
            end
            vectors++;
            if (overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL overflow cyc %0d: got %b want %0d", cyc, overflow, m_ovf);
            end
            vectors++;
            if (proto_err !== m_perr) begin
                miscompares++;
                $display("FAIL proto_err cyc %0d: got %b want %0d", cyc, proto_err, m_perr);
            end
            vectors++;
            if (busy !== m_busy) begin
                miscompares++;
                $display("FAIL busy cyc %0d: got %b want %0d", cyc, busy, m_busy);
            end
            if (prev_stall) begin
                vectors++;
                if (out_data !== prev_data || out_id !== prev_id || out_step !== prev_step || out_last !== prev_last) begin
                    miscompares++;
                    $display("FAIL stall_hold cyc %0d: got id %0d data %h want id %0d data %h", cyc, out_id, out_data, prev_id, prev_data);
                end
            end
            if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid === 1'b1 && rdy && !rs) begin
                got_ids.push_back(int'(out_id));
                got_steps.push_back(int'(out_step));
                got_last.push_back(int'(out_last));
            end
        end
        prev_stall = sb_on && (out_valid === 1'b1) && !rdy && !rs;
        prev_data  = out_data;
        prev_id    = out_id;
        prev_step  = out_step;
        prev_last  = out_last;

        rst          = rs;
        dump_rd_en   = en;
        dump_rd_addr = IDW'(addr);
        out_ready    = rdy;

        if (rs) begin
            pipe.delete();
            for (int i = 0; i < LAT; i++) pipe.push_back('{en: '0, addr: 0});
            q.delete();
            m_ovf  = 1'b0;
            m_perr = 1'b0;
            m_busy = 1'b0;
            sb_on  = 1'b1;
        end else begin
            pipe.push_back('{en: en, addr: addr});
            d = pipe.pop_front();
            for (int s = 0; s < NS; s++) step_rd_data[s*PW +: PW] = PW'(data_of(s, d.addr));
            pop = (q.size() != 0) && rdy;
            acc = 1'b0;
            if (d.en != '0) begin
                k = 0;
                for (int i = NS - 1; i >= 0; i--) if (d.en[i]) k = i;
                e = '{step: k, id: d.addr, data: data_of(k, d.addr), last: (d.addr == NUM_PARTICLES_PER_CELL - 1)};
                if ($countones(d.en) > 1) m_perr = 1'b1;
                if (q.size() < DEPTH || pop) acc = 1'b1;
                else m_ovf = 1'b1;
            end
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
            m_busy = (q.size() != 0) || (inflight_cnt() != 0);
        end
        cyc++;
    endtask

    task automatic drain(input bit rand_rdy);
        int n = 0;
        while ((q.size() != 0 || m_busy) && n < 200) begin
            tick('0, 0, rand_rdy ? bit'($urandom_range(0, 1)) : 1'b1, 1'b0);
            n++;
        end
        vectors++;
        if (q.size() != 0 || m_busy) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d entries left after %0d cycles, want 0", q.size(), n);
        end
    endtask

    task automatic clear_got();
        got_ids.delete();
        got_steps.delete();
        got_last.delete();
    endtask

    task automatic test_reset();
        tick('0, 0, 1'b0, 1'b1);
        tick('0, 0, 1'b0, 1'b1);
        tick('0, 0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || proto_err !== 1'b0 ||
            out_data !== '0 || out_id !== '0 || out_step !== '0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got valid %b busy %b ovf %b perr %b data %h id %0d step %0d last %b want all 0",
                     out_valid, busy, overflow, proto_err, out_data, out_id, out_step, out_last);
        end
    endtask

    task automatic test_burst();
        int c;
        clear_got();
        first_valid_cyc = -1;
        c = cyc;
        for (int a = 0; a < 8; a++) tick(4'b0100, a, 1'b1, 1'b0);
        drain(1'b0);
        vectors++;
        if (first_valid_cyc != c + LAT + 1) begin
            miscompares++;
            $display("FAIL burst_latency: got %0d cycles want %0d", first_valid_cyc - c, LAT + 1);
        end
        vectors++;
        if (got_ids.size() != 8) begin
            miscompares++;
            $display("FAIL burst_count: got %0d want 8", got_ids.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (got_ids[i] != i || got_steps[i] != 2 || got_last[i] != (i == 7 ? 1 : 0)) begin
                    miscompares++;
                    $display("FAIL burst_entry %0d: got id %0d step %0d last %0d want id %0d step 2 last %0d",
                             i, got_ids[i], got_steps[i], got_last[i], i, (i == 7));
                end
            end
        end
    endtask

    task automatic test_overflow();
        clear_got();
        for (int a = 0; a < 8; a++) tick(4'b0100, a, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick('0, 0, 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_no_ovf: got ovf %b valid %b want 0 1", overflow, out_valid);
        end
        tick(4'b0100, 5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick('0, 0, 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ninth_push_ovf: got %b want 1", overflow);
        end
        drain(1'b0);
        vectors++;
        if (got_ids.size() != 8) begin
            miscompares++;
            $display("FAIL ovf_drain_count: got %0d want 8", got_ids.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (got_ids[i] != i) begin
                    miscompares++;
                    $display("FAIL ovf_drain_id %0d: got %0d want %0d", i, got_ids[i], i);
                end
            end
        end
        tick('0, 0, 1'b0, 1'b1);
        tick('0, 0, 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_cleared_by_rst: got %b want 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        int exp_ids[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 3};
        clear_got();
        for (int a = 0; a < 8; a++) tick(4'b0001, a, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick('0, 0, 1'b0, 1'b0);
        tick(4'b0001, 3, 1'b0, 1'b0);
        tick('0, 0, 1'b0, 1'b0);
        tick('0, 0, 1'b1, 1'b0);
        tick('0, 0, 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL full_push_pop_ovf: got %b want 0", overflow);
        end
        drain(1'b0);
        vectors++;
        if (got_ids.size() != 9) begin
            miscompares++;
            $display("FAIL full_push_pop_count: got %0d want 9", got_ids.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                vectors++;
                if (got_ids[i] != exp_ids[i]) begin
                    miscompares++;
                    $display("FAIL full_push_pop_id %0d: got %0d want %0d", i, got_ids[i], exp_ids[i]);
                end
            end
        end
    endtask

    task automatic test_proto();
        clear_got();
        tick(4'b0110, 5, 1'b1, 1'b0);
        drain(1'b0);
        vectors++;
        if (proto_err !== 1'b1 || got_steps.size() != 1 || (got_steps.size() == 1 && got_steps[0] != 1)) begin
            miscompares++;
            $display("FAIL proto_err_entry: got perr %b entries %0d step %0d want 1 1 1",
                     proto_err, got_steps.size(), (got_steps.size() != 0) ? got_steps[0] : -1);
        end
        tick('0, 0, 1'b0, 1'b1);
        tick('0, 0, 1'b0, 1'b0);
        vectors++;
        if (proto_err !== 1'b0) begin
            miscompares++;
            $display("FAIL proto_cleared_by_rst: got %b want 0", proto_err);
        end
    endtask

    task automatic test_mid_reset();
        for (int a = 0; a < 4; a++) tick(4'b1000, a, 1'b0, 1'b0);
        tick('0, 0, 1'b0, 1'b1);
        tick('0, 0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_flush: got valid %b busy %b want 0 0", out_valid, busy);
        end
        clear_got();
        for (int i = 0; i < 10; i++) tick('0, 0, 1'b1, 1'b0);
        vectors++;
        if (got_ids.size() != 0) begin
            miscompares++;
            $display("FAIL mid_reset_stale: got %0d entries want 0", got_ids.size());
        end
    endtask

    task automatic test_back_to_back();
        int exp_ids[$];
        int exp_steps[$];
        int guard = 0;
        clear_got();
        for (int s = 0; s < NS; s++) begin
            for (int a = 0; a < 8; a++) begin
                while (q.size() + inflight_cnt() >= DEPTH && guard < 2000) begin
                    tick('0, 0, bit'($urandom_range(0, 1)), 1'b0);
                    guard++;
                end
                tick(NS'(1 << s), a, bit'($urandom_range(0, 1)), 1'b0);
                exp_ids.push_back(a);
                exp_steps.push_back(s);
            end
        end
        drain(1'b1);
        vectors++;
        if (got_ids.size() != exp_ids.size() || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d entries ovf %b want %0d ovf 0", got_ids.size(), overflow, exp_ids.size());
        end else begin
            for (int i = 0; i < exp_ids.size(); i++) begin
                vectors++;
                if (got_ids[i] != exp_ids[i] || got_steps[i] != exp_steps[i]) begin
                    miscompares++;
                    $display("FAIL b2b_order %0d: got step %0d id %0d want step %0d id %0d",
                             i, got_steps[i], got_ids[i], exp_steps[i], exp_ids[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        tick('0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            tick(($urandom_range(0, 2) == 0) ? NS'(0) : NS'($urandom_range(1, 15)),
                 $urandom_range(0, 7), bit'($urandom_range(0, 1)), 1'b0);
        end
        drain(1'b1);
        tick('0, 0, 1'b0, 1'b1);
        tick('0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_burst();
        test_overflow();
        test_full_push_pop();
        test_proto();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
